fifo_sync_param: RTL
====================

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, pointer width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter AF_LEVEL, default 12, almost-full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold (0..DEPTH-2).
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr  input  1  write request.
REQ-009 SHALL have port rd  input  1  read request.
REQ-010 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have port data_in  input  DATA_W  write data.
REQ-012 SHALL have port data_out  output  DATA_W  read data.
REQ-013 SHALL have port count  output  ADDR_W+1  current fill level, 0..DEPTH.
REQ-014 SHALL have ports fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty  output  1 each  status flags.
REQ-015 SHALL have ports fifo_overflow, fifo_underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write on a clock edge when wr=1 and (count<DEPTH, or count=DEPTH and rd=1); stores data_in at wptr, wptr increments modulo DEPTH.
REQ-017 SHALL accept a read on a clock edge when rd=1 and count>0; rptr increments modulo DEPTH.
REQ-018 SHALL update count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read.
REQ-019 SHALL at full with wr=1, rd=1: accept both, count stays DEPTH, no overflow.
REQ-020 SHALL at empty with wr=1, rd=1: accept write only, read rejected, count becomes 1, fifo_underflow set.
REQ-021 SHALL derive flags combinationally from count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-022 SHALL set fifo_overflow on a rejected write (wr=1, full, rd=0); memory, wptr and count unchanged.
REQ-023 SHALL set fifo_underflow on a rejected read (rd=1, empty); rptr, count and data_out unchanged.
REQ-024 SHALL hold overflow/underflow set until clr_err=1 at a clock edge; an error event on the same edge as clr_err takes priority (flag remains 1).
REQ-025 FWFT=0: SHALL load data_out from mem[rptr] on an accepted-read edge (one-cycle latency); otherwise hold.
REQ-026 FWFT=1: SHALL drive data_out = mem[rptr] combinationally whenever not empty; value is don't-care when empty; rd pops the presented word.
REQ-027 SHALL preserve pointer wrap-around: data order strictly first-in first-out across any number of wraps.

Reset
REQ-028 SHALL on rst=1, asynchronously: wptr=0, rptr=0, count=0, data_out=0 (FWFT=0), fifo_overflow=0, fifo_underflow=0; hence fifo_empty=1, fifo_almost_empty=1, fifo_full=0, fifo_almost_full=0.
REQ-029 SHALL not clear memory contents on reset; reset mid-operation discards all stored words.
REQ-030 SHALL ignore wr, rd, clr_err while rst=1 and resume operation on the first rising edge after rst deasserts.

Verification (defaults, FWFT=0 unless stated)
REQ-031 Write 0x01..0x10 (16 words) -> full=1 at count=16, almost_full=1 from count=12; then 16 reads -> data_out 0x01..0x10 in order, each one cycle after rd; empty=1 at end.
REQ-032 Full FIFO, wr=1, rd=0 with 0xAA -> overflow=1, count=16, later reads contain no 0xAA; clr_err pulse -> overflow=0.
REQ-033 Empty FIFO, rd=1 -> underflow=1, data_out unchanged; same cycle wr=1 data 0x55 -> count=1, next read returns 0x55.
REQ-034 Full FIFO, wr=1 and rd=1 for 20 cycles with incrementing data -> count stays 16, no overflow/underflow, output sequence continuous across pointer wrap.
REQ-035 Write 5 words, assert rst mid-cycle -> count=0, empty=1, flags 0 immediately without clock edge; subsequent write/read returns new data only.
REQ-036 FWFT=1: write 0x33 -> data_out=0x33 while empty=0 before any rd; rd pops it and empty=1.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with registered or first-word-fall-through read and
// count-derived status flags. Overflow and underflow flags stay set until cleared.
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W:0]   count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              full, empty;
    logic              wr_ok, rd_ok;

    always_comb begin
        full  = (count_q == DEPTH_C);
        empty = (count_q == '0);
        // A write into a full FIFO is fine when the same edge frees a slot.
        wr_ok = wr & (~full | rd);
        rd_ok = rd & ~empty;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_ok) wptr_d = wptr_q + 1'b1;
        if (rd_ok) rptr_d = rptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error on the clearing edge wins over the clear.
        ovf_d = (wr & full & ~rd) | (ovf_q & ~clr_err);
        udf_d = (rd & empty) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is intentionally not reset; the pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem_q[wptr_q] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem_q[rptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_ok) dout_d = mem_q[rptr_q];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) dout_q <= '0;
                else     dout_q <= dout_d;
            end

            assign data_out = dout_q;
        end
    endgenerate

    assign count             = count_q;
    assign fifo_full         = full;
    assign fifo_empty        = empty;
    assign fifo_almost_full  = (count_q >= AF_C);
    assign fifo_almost_empty = (count_q <= AE_C);
    assign fifo_overflow     = ovf_q;
    assign fifo_underflow    = udf_q;

endmodule
